gate_net_sweep_ctrl: RTL and testbench

Sequencer and checker for the six-input gate network Y = ~(~(A&B) & (C&~B&D) & ~(E|F)).
- Drives one input vector at a time into the network and holds it for a programmable settle time.
- Samples the network output, compares it against an internal golden model, and streams one result per vector over a valid/ready handshake.
- Sits between a host or bench controller and the network under test.
- Replaces hand-written per-vector stimulus with a configurable sweep.

---
 rtl/gate_net_pkg.sv | 23 ++
 rtl/gate_net_ref.sv | 20 ++
 rtl/gate_net_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_gate_net_sweep_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gate_net_pkg.sv
// rtl/gate_net_pkg.sv - shared types and constants for the gate network sweep controller
package gate_net_pkg;

  localparam int VEC_W = 6;

  // Bit positions of the network inputs inside a vector {A,B,C,D,E,F}
  localparam int BIT_A = 5;
  localparam int BIT_B = 4;
  localparam int BIT_C = 3;
  localparam int BIT_D = 2;
  localparam int BIT_E = 1;
  localparam int BIT_F = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_REPORT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/gate_net_ref.sv
// rtl/gate_net_ref.sv - combinational golden model of Y = ~(~(A&B) & (C&~B&D) & ~(E|F))
module gate_net_ref
  import gate_net_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             y
);

  logic a, b, c, d, e, f;

  assign a = vec[BIT_A];
  assign b = vec[BIT_B];
  assign c = vec[BIT_C];
  assign d = vec[BIT_D];
  assign e = vec[BIT_E];
  assign f = vec[BIT_F];

  assign y = ~(~(a & b) & (c & ~b & d) & ~(e | f));

endmodule

// File: rtl/gate_net_sweep_ctrl.sv
// rtl/gate_net_sweep_ctrl.sv - sweeps input vectors through the gate network and checks each
// sampled output against the golden model, streaming one result per vector.
module gate_net_sweep_ctrl
  import gate_net_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       cfg_first,
  input  logic [5:0]       cfg_last,
  output logic [5:0]       vec_out,
  input  logic             net_y,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [5:0]       res_vec,
  output logic             res_y,
  output logic             res_exp,
  output logic [CNT_W-1:0] err_cnt,
  output logic [5:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);

  state_t           state;
  logic [7:0]       settle_cnt;
  logic [VEC_W-1:0] last_r;
  logic             exp_y;
  logic             in_sweep;

  gate_net_ref u_ref (
    .vec (vec_out),
    .y   (exp_y)
  );

  assign in_sweep = (state == ST_APPLY) || (state == ST_SETTLE) ||
                    (state == ST_SAMPLE) || (state == ST_REPORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      settle_cnt      <= '0;
      last_r          <= '0;
      vec_out         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      res_valid       <= 1'b0;
      res_vec         <= '0;
      res_y           <= 1'b0;
      res_exp         <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort wins over everything else, including a result handshake in the same cycle
      if (abort && in_sweep) begin
        state     <= ST_DONE;
        done      <= 1'b1;
        busy      <= 1'b0;
        aborted   <= 1'b1;
        res_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              last_r          <= cfg_last;
              vec_out         <= cfg_first;
              err_cnt         <= '0;
              first_err_vec   <= '0;
              first_err_valid <= 1'b0;
              aborted         <= 1'b0;
              busy            <= 1'b1;
              state           <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            settle_cnt <= SETTLE_LD;
            state      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            settle_cnt <= settle_cnt - 8'd1;
            if (settle_cnt == 8'd1) begin
              state <= ST_SAMPLE;
            end
          end
          ST_SAMPLE: begin
            res_vec   <= vec_out;
            res_y     <= net_y;
            res_exp   <= exp_y;
            res_valid <= 1'b1;
            if (net_y != exp_y) begin
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
              end
              if (!first_err_valid) begin
                first_err_vec   <= vec_out;
                first_err_valid <= 1'b1;
              end
            end
            state <= ST_REPORT;
          end
          ST_REPORT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (vec_out == last_r) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                vec_out <= vec_out + 6'd1;
                state   <= ST_APPLY;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_net_sweep_ctrl.sv
// tb/tb_gate_net_sweep_ctrl.sv - randomized self-checking bench for gate_net_sweep_ctrl
module tb_gate_net_sweep_ctrl;

  localparam int S     = 4;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst, start, abort, res_ready;
  logic [5:0]       cfg_first, cfg_last, vec_out, res_vec, first_err_vec;
  logic             net_y, busy, done, aborted, res_valid, res_y, res_exp, first_err_valid;
  logic [CNT_W-1:0] err_cnt;

  logic flip [64];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  // Network under test: the textbook expression, optionally corrupted per vector
  function automatic logic net_fn(input logic [5:0] v);
    logic a, b, c, d, e, f;
    {a, b, c, d, e, f} = v;
    return ~(~(a & b) & (c & ~b & d) & ~(e | f));
  endfunction

  // Expected value from the truth table: Y is low only at 0x0C and 0x2C
  function automatic logic exp_fn(input logic [5:0] v);
    return !(v == 6'h0C || v == 6'h2C);
  endfunction

  assign net_y = net_fn(vec_out) ^ flip[vec_out];

  gate_net_sweep_ctrl #(.SETTLE_CYC(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_first(cfg_first), .cfg_last(cfg_last), .vec_out(vec_out), .net_y(net_y),
    .busy(busy), .done(done), .aborted(aborted),
    .res_valid(res_valid), .res_ready(res_ready), .res_vec(res_vec),
    .res_y(res_y), .res_exp(res_exp), .err_cnt(err_cnt),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // mode 0: good network, 1: stuck-at-1, 2: random per-vector faults
  task automatic run_sweep(input logic [5:0] f, input logic [5:0] l, input int mode,
                           input int pct, input int stall_idx, input int stall_len,
                           input int abort_idx);
    int n, got, stalls, busy_cyc, errs, since, stall_cnt;
    logic hold, ab_sent, fe_valid;
    logic [5:0] fe_vec, ev, h_vec;
    logic h_y, h_exp, y_exp;
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       flip[i] = 1'b0;
        1:       flip[i] = ~net_fn(6'(i));
        default: flip[i] = ($urandom_range(0, 3) == 0);
      endcase
    end
    n = ((int'(l) - int'(f) + 64) % 64) + 1;
    got = 0; stalls = 0; busy_cyc = 0; errs = 0; since = 0; stall_cnt = 0;
    hold = 0; ab_sent = 0; fe_valid = 0; fe_vec = '0;
    h_vec = '0; h_y = 0; h_exp = 0;
    @(negedge clk);
    cfg_first = f; cfg_last = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_vec", 32'(vec_out), 32'(f));
    for (int cyc = 0; cyc < 5000; cyc++) begin
      start = 1'b0;
      abort = 1'b0;
      if (done) break;
      if (busy) busy_cyc++;
      if (hold) begin
        check("hold_vec", 32'(res_vec), 32'(h_vec));
        check("hold_y", 32'(res_y), 32'(h_y));
        check("hold_exp", 32'(res_exp), 32'(h_exp));
      end
      if (res_valid) begin
        ev = f + 6'(got);
        y_exp = exp_fn(ev) ^ flip[ev] ^ (net_fn(ev) ^ exp_fn(ev));
        if (!hold) begin
          check("res_vec", 32'(res_vec), 32'(ev));
          check("res_exp", 32'(res_exp), 32'(exp_fn(ev)));
          check("res_y", 32'(res_y), 32'(y_exp));
        end
        if (got == stall_idx && stall_cnt < stall_len) begin
          res_ready = 1'b0;
          stall_cnt++;
        end else begin
          res_ready = ($urandom_range(1, 100) <= pct);
        end
        if (res_ready) begin
          if (y_exp != exp_fn(ev)) begin
            errs++;
            if (!fe_valid) begin fe_valid = 1; fe_vec = ev; end
          end
          got++;
          hold = 0;
          since = 0;
        end else begin
          hold = 1; h_vec = res_vec; h_y = res_y; h_exp = res_exp;
          stalls++;
        end
      end else begin
        res_ready = $urandom_range(0, 1);
        if (busy) since++;
        if (abort_idx >= 0 && got == abort_idx && since == 2 && !ab_sent) begin
          abort = 1'b1;
          ab_sent = 1;
        end
      end
      if (busy && !abort && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        cfg_first = 6'($urandom);
        cfg_last = 6'($urandom);
      end
      @(negedge clk);
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("aborted", 32'(aborted), 32'(ab_sent));
    check("n_results", 32'(got), ab_sent ? 32'(abort_idx) : 32'(n));
    check("err_cnt", 32'(err_cnt), 32'(errs > 127 ? 127 : errs));
    check("first_err_valid", 32'(first_err_valid), 32'(fe_valid));
    check("first_err_vec", 32'(first_err_vec), 32'(fe_vec));
    check("vec_hold", 32'(vec_out), ab_sent ? 32'(6'(f + 6'(abort_idx))) : 32'(l));
    if (!ab_sent) check("sweep_cycles", 32'(busy_cyc), 32'(n * (S + 3) + stalls));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    cfg_first = '0; cfg_last = '0;
    for (int i = 0; i < 64; i++) flip[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outs", {vec_out, busy, done, aborted, res_valid, res_vec, res_y, res_exp,
                         err_cnt, first_err_vec, first_err_valid}, 32'd0);

    run_sweep(6'h00, 6'h3F, 0, 100, -1, 0, -1);
    run_sweep(6'h00, 6'h3F, 1, 100, -1, 0, -1);
    run_sweep(6'h24, 6'h24, 0, 100, -1, 0, -1);
    run_sweep(6'h3E, 6'h01, 0, 100, -1, 0, -1);
    run_sweep(6'h00, 6'h07, 0, 100, 1, 10, -1);
    run_sweep(6'h00, 6'h3F, 0, 100, -1, 0, 5);
    for (int k = 0; k < 6; k++) begin
      run_sweep(6'($urandom), 6'($urandom), 2, 60, -1, 0, -1);
    end

    // Reset while a result is pending
    @(negedge clk);
    cfg_first = 6'h10; cfg_last = 6'h20; res_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && !res_valid; cyc++) @(negedge clk);
    check("rst_in_report", 32'(res_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outs", {vec_out, busy, done, aborted, res_valid, res_vec, res_y, res_exp,
                       err_cnt, first_err_vec, first_err_valid}, 32'd0);
    rst = 1'b0;
    res_ready = 1'b1;
    run_sweep(6'h2A, 6'h2E, 2, 80, -1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
